multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Moore-style control FSM that sequences a multi-cycle RV32I datapath: one shared ALU, one shared instruction/data memory port, and IR, OldPC, A/B and ALUOut holding registers.
- Takes the instruction opcode and the branch comparator result. Drives per-cycle mux selects, write enables and a memory request handshake.
- Replaces the single-cycle main decoder in the multi-cycle core variant. Keeps the same ImmSrc and ALUOp encodings.

Parameters:
- None. All encodings are fixed in the shared package.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- op  in  7  opcode field of IR (IR[6:0]), valid from DECODE onward
- branch_taken  in  1  branch comparator result for the current funct3
- mem_ready  in  1  memory completes the access this cycle
- mem_req  out  1  memory access request, held until mem_ready
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  out  1  store strobe, qualified by mem_req
- IRWrite  out  1  load IR and OldPC
- PCWrite  out  1  PC register enable
- RegWrite  out  1  register file write
- ALUSrcA  out  2  ALU A operand: 00=PC, 01=OldPC, 10=A(rs1), 11=zero
- ALUSrcB  out  2  ALU B operand: 00=B(rs2), 01=ImmExt, 10=constant 4
- ALUOp  out  2  00=add, 01=branch compare/sub, 10=funct decode
- ImmSrc  out  3  000 none, 001 I, 010 S, 011 B, 100 U, 101 J
- ResultSrc  out  2  00=ALUOut, 01=read data, 10=ALUResult
- retire  out  1  one-cycle pulse in the final cycle of each instruction
- illegal_instr  out  1  sticky, set on an unsupported opcode

Behaviour:
- States: RESET, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, JALR_LINK, LUI, ILLEGAL.
- Outputs are a pure function of state, plus op, mem_ready and branch_taken where stated. Any output not listed for a state is 0.
- ImmSrc is decoded from op in every state except RESET and FETCH: load/OP-IMM/JALR=001, store=010, branch=011, LUI/AUIPC=100, JAL=101, else 000.
- Reset (asynchronous, any state): state becomes RESET. In RESET all outputs are 0 and illegal_instr clears. RESET goes to FETCH on the next clock.
- FETCH:
  - mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite=PCWrite=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00, so ALUOut = OldPC+imm. Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 0010111 (AUIPC) -> ALUWB directly; ALUOut already holds the result
  - any other opcode -> ILLEGAL
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: mem_req=1, AdrSrc=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, retire=1. Goes to FETCH.
- MEMWRITE:
  - mem_req=1, AdrSrc=1, MemWrite=1.
  - Waits for mem_ready.
  - On mem_ready: retire=1, go to FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Goes to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, retire=1. Goes to FETCH.
- BRANCH:
  - ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00.
  - PCWrite=branch_taken; a taken branch loads the target held in ALUOut.
  - retire=1. Goes to FETCH.
- JAL:
  - ALUSrcA=01, ALUSrcB=10, ALUOp=00, so ALUOut = OldPC+4.
  - ResultSrc=00, PCWrite=1 (loads the target computed in DECODE).
  - Goes to ALUWB.
- JALR:
  - ALUSrcA=10, ALUSrcB=01, ALUOp=00, ResultSrc=10, PCWrite=1.
  - The datapath clears bit 0 of the target.
  - Goes to JALR_LINK.
- JALR_LINK: ALUSrcA=01, ALUSrcB=10, ALUOp=00. Goes to ALUWB.
- ILLEGAL: illegal_instr=1. The FSM stays here until reset. No writes, no mem_req.
- Memory handshake:
  - mem_req stays high and AdrSrc/MemWrite stay stable until the cycle in which mem_ready=1.
  - mem_ready is ignored in every state that does not assert mem_req.
- Cycle counts with zero wait states:
  - load 5, store 4, R/I ALU 4, branch 3, JAL 4, JALR 5, LUI 4, AUIPC 3.
  - Each memory wait cycle adds 1.

Decomposition:
- Package mc_ctrl_pkg contains:
  - state enum (4-bit)
  - opcode localparams
  - ImmSrc, ALUOp, ResultSrc, ALUSrcA/B encodings
- Sub-module imm_src_decode: combinational op -> ImmSrc. Shared with the single-cycle core's decoder table.
- The FSM (next-state and output logic) stays in this module.

Test Plan:
- Reset then ADDI with mem_ready=1 every cycle:
  - Expect states RESET, FETCH, DECODE, EXECI, ALUWB.
  - ImmSrc=001; RegWrite=1 only in ALUWB.
  - retire pulses once in cycle 4 after FETCH.
- LW with mem_ready low for 2 cycles in FETCH and 3 in MEMREAD:
  - mem_req stays high throughout each wait.
  - IRWrite/PCWrite assert exactly once.
  - AdrSrc=1 in MEMREAD; total 10 cycles to retire.
- BEQ with branch_taken=1, then BEQ with branch_taken=0:
  - PCWrite asserts in BRANCH only for the taken case.
  - ALUOp=01, ImmSrc=011.
- JALR:
  - JALR cycle has PCWrite=1 and ResultSrc=10.
  - JALR_LINK has ALUSrcA=01 and ALUSrcB=10.
  - RegWrite in ALUWB; 5 cycles total.
- op=0000000 in DECODE:
  - Enters ILLEGAL; illegal_instr=1 and all other outputs 0.
  - Stays there for 20 cycles; rst_n low clears it.
- rst_n asserted asynchronously mid-MEMWRITE with mem_req=1:
  - All outputs drop to 0 in the same cycle, without waiting for a clock edge.
  - No MemWrite after release; the FSM restarts at FETCH.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mc_ctrl_pkg - state, opcode and datapath-select encodings for the multi-cycle control FSM
// Revision: 1.0
// ----------------------------------------------------------------------------
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEMADR    = 4'd3,
    S_MEMREAD   = 4'd4,
    S_MEMWB     = 4'd5,
    S_MEMWRITE  = 4'd6,
    S_EXECR     = 4'd7,
    S_EXECI     = 4'd8,
    S_ALUWB     = 4'd9,
    S_BRANCH    = 4'd10,
    S_JAL       = 4'd11,
    S_JALR      = 4'd12,
    S_JALR_LINK = 4'd13,
    S_LUI       = 4'd14,
    S_ILLEGAL   = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_NONE = 3'b000;
  localparam logic [2:0] IMM_I    = 3'b001;
  localparam logic [2:0] IMM_S    = 3'b010;
  localparam logic [2:0] IMM_B    = 3'b011;
  localparam logic [2:0] IMM_U    = 3'b100;
  localparam logic [2:0] IMM_J    = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_RDATA     = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage
`default_nettype wire

// File: rtl/imm_src_decode.sv
`default_nettype none
// ----------------------------------------------------------------------------
// imm_src_decode - opcode to immediate-format select, shared with the single-cycle decoder
// Revision: 1.0
// ----------------------------------------------------------------------------
module imm_src_decode
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic [2:0] imm_src
);

  always_comb begin
    imm_src = IMM_NONE;
    case (op)
      OP_LOAD, OP_IMM, OP_JALR: imm_src = IMM_I;
      OP_STORE:                 imm_src = IMM_S;
      OP_BRANCH:                imm_src = IMM_B;
      OP_LUI, OP_AUIPC:         imm_src = IMM_U;
      OP_JAL:                   imm_src = IMM_J;
      default:                  imm_src = IMM_NONE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// multicycle_controller - Moore control FSM for the multi-cycle RV32I datapath
// Revision: 1.0
// ----------------------------------------------------------------------------
module multicycle_controller
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic [1:0] ResultSrc,
  output logic       retire,
  output logic       illegal_instr
);

  state_t     r_state;
  state_t     w_state_next;
  logic [2:0] w_imm_src;

  imm_src_decode u_imm_src_decode (
    .op      (op),
    .imm_src (w_imm_src)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_RESET;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    mem_req       = 1'b0;
    AdrSrc        = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    PCWrite       = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_RS2;
    ALUOp         = ALUOP_ADD;
    ImmSrc        = IMM_NONE;
    ResultSrc     = RES_ALUOUT;
    retire        = 1'b0;
    illegal_instr = 1'b0;

    // op is not yet loaded into IR before DECODE
    if (r_state != S_RESET && r_state != S_FETCH) ImmSrc = w_imm_src;

    case (r_state)
      S_RESET: w_state_next = S_FETCH;
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) w_state_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: w_state_next = S_MEMADR;
          OP_R:              w_state_next = S_EXECR;
          OP_IMM:            w_state_next = S_EXECI;
          OP_BRANCH:         w_state_next = S_BRANCH;
          OP_JAL:            w_state_next = S_JAL;
          OP_JALR:           w_state_next = S_JALR;
          OP_LUI:            w_state_next = S_LUI;
          OP_AUIPC:          w_state_next = S_ALUWB;
          default:           w_state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA      = SRCA_RS1;
        ALUSrcB      = SRCB_IMM;
        w_state_next = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) w_state_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc    = RES_RDATA;
        RegWrite     = 1'b1;
        retire       = 1'b1;
        w_state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        retire   = mem_ready;
        if (mem_ready) w_state_next = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA      = SRCA_RS1;
        ALUSrcB      = SRCB_RS2;
        ALUOp        = ALUOP_FUNCT;
        w_state_next = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA      = SRCA_RS1;
        ALUSrcB      = SRCB_IMM;
        ALUOp        = ALUOP_FUNCT;
        w_state_next = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite     = 1'b1;
        retire       = 1'b1;
        w_state_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA      = SRCA_RS1;
        ALUOp        = ALUOP_SUB;
        PCWrite      = branch_taken;
        retire       = 1'b1;
        w_state_next = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA      = SRCA_OLDPC;
        ALUSrcB      = SRCB_FOUR;
        PCWrite      = 1'b1;
        w_state_next = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA      = SRCA_RS1;
        ALUSrcB      = SRCB_IMM;
        ResultSrc    = RES_ALURESULT;
        PCWrite      = 1'b1;
        w_state_next = S_JALR_LINK;
      end
      S_JALR_LINK: begin
        ALUSrcA      = SRCA_OLDPC;
        ALUSrcB      = SRCB_FOUR;
        w_state_next = S_ALUWB;
      end
      S_LUI: begin
        // zero + U-immediate lands the upper immediate in ALUOut for ALUWB
        ALUSrcA      = SRCA_ZERO;
        ALUSrcB      = SRCB_IMM;
        w_state_next = S_ALUWB;
      end
      S_ILLEGAL: illegal_instr = 1'b1;
      default:   w_state_next = S_RESET;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_multicycle_controller - directed per-cycle output checks of the multi-cycle control FSM
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'd0;
  logic       branch_taken = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, retire, illegal_instr;
  logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
  logic [2:0] ImmSrc;
  logic [18:0] obs;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk (clk), .rst_n (rst_n), .op (op), .branch_taken (branch_taken),
    .mem_ready (mem_ready), .mem_req (mem_req), .AdrSrc (AdrSrc),
    .MemWrite (MemWrite), .IRWrite (IRWrite), .PCWrite (PCWrite),
    .RegWrite (RegWrite), .ALUSrcA (ALUSrcA), .ALUSrcB (ALUSrcB),
    .ALUOp (ALUOp), .ImmSrc (ImmSrc), .ResultSrc (ResultSrc),
    .retire (retire), .illegal_instr (illegal_instr)
  );

  assign obs = {mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
                ALUSrcA, ALUSrcB, ALUOp, ImmSrc, ResultSrc, retire, illegal_instr};

  function automatic logic [18:0] mk(input logic mq, ad, mw, ir, pc, rw,
                                     input logic [1:0] sa, sb, ao,
                                     input logic [2:0] im,
                                     input logic [1:0] rs,
                                     input logic rt, il);
    return {mq, ad, mw, ir, pc, rw, sa, sb, ao, im, rs, rt, il};
  endfunction

  // {mem_ready, branch_taken, expected outputs}
  function automatic logic [20:0] v(input logic mr, bt, input logic [18:0] e);
    return {mr, bt, e};
  endfunction

  function automatic logic [20:0] fetch_ok();
    return v(1'b1, 1'b0, mk(1,0,0,1,1,0, 2'd0,2'd2,2'd0, 3'd0, 2'd2, 0,0));
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== 19'd0) begin errors++; $display("FAIL reset_hold got %h expected %h", obs, 19'd0); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== 19'd0) begin errors++; $display("FAIL reset_state got %h expected %h", obs, 19'd0); end
    @(posedge clk); #1;
  endtask

  task automatic test_addi();
    logic [20:0] q[$];
    int nret = 0;
    op = 7'b0010011;
    q.push_back(fetch_ok());
    q.push_back(v(1,0, mk(0,0,0,0,0,0, 2'd1,2'd1,2'd0, 3'd1, 2'd0, 0,0)));
    q.push_back(v(1,0, mk(0,0,0,0,0,0, 2'd2,2'd1,2'd2, 3'd1, 2'd0, 0,0)));
    q.push_back(v(1,0, mk(0,0,0,0,0,1, 2'd0,2'd0,2'd0, 3'd1, 2'd0, 1,0)));
    foreach (q[i]) begin
      mem_ready = q[i][20]; branch_taken = q[i][19]; #1;
      nret += int'(retire);
      checks++;
      if (obs !== q[i][18:0]) begin errors++; $display("FAIL addi cycle %0d got %h expected %h", i, obs, q[i][18:0]); end
      @(posedge clk); #1;
    end
    checks++;
    if (nret != 1) begin errors++; $display("FAIL addi_retire_count got %0d expected 1", nret); end
  endtask

  task automatic test_lw_waits();
    logic [20:0] q[$];
    int nir = 0;
    op = 7'b0000011;
    q.push_back(v(0,0, mk(1,0,0,0,0,0, 2'd0,2'd2,2'd0, 3'd0, 2'd2, 0,0)));
    q.push_back(v(0,0, mk(1,0,0,0,0,0, 2'd0,2'd2,2'd0, 3'd0, 2'd2, 0,0)));
    q.push_back(fetch_ok());
    q.push_back(v(1,0, mk(0,0,0,0,0,0, 2'd1,2'd1,2'd0, 3'd1, 2'd0, 0,0)));
    q.push_back(v(1,0, mk(0,0,0,0,0,0, 2'd2,2'd1,2'd0, 3'd1, 2'd0, 0,0)));
    q.push_back(v(0,0, mk(1,1,0,0,0,0, 2'd0,2'd0,2'd0, 3'd1, 2'd0, 0,0)));
    q.push_back(v(0,0, mk(1,1,0,0,0,0, 2'd0,2'd0,2'd0, 3'd1, 2'd0, 0,0)));
    q.push_back(v(0,0, mk(1,1,0,0,0,0, 2'd0,2'd0,2'd0, 3'd1, 2'd0, 0,0)));
    q.push_back(v(1,0, mk(1,1,0,0,0,0, 2'd0,2'd0,2'd0, 3'd1, 2'd0, 0,0)));
    q.push_back(v(1,0, mk(0,0,0,0,0,1, 2'd0,2'd0,2'd0, 3'd1, 2'd1, 1,0)));
    foreach (q[i]) begin
      mem_ready = q[i][20]; branch_taken = q[i][19]; #1;
      nir += int'(IRWrite);
      checks++;
      if (obs !== q[i][18:0]) begin errors++; $display("FAIL lw cycle %0d got %h expected %h", i, obs, q[i][18:0]); end
      @(posedge clk); #1;
    end
    checks++;
    if (nir != 1) begin errors++; $display("FAIL lw_irwrite_count got %0d expected 1", nir); end
  endtask

  task automatic test_branch();
    logic [20:0] q[$];
    op = 7'b1100011;
    for (int t = 1; t >= 0; t--) begin
      q.push_back(fetch_ok());
      q.push_back(v(1,t[0], mk(0,0,0,0,0,0, 2'd1,2'd1,2'd0, 3'd3, 2'd0, 0,0)));
      q.push_back(v(1,t[0], mk(0,0,0,0,t[0],0, 2'd2,2'd0,2'd1, 3'd3, 2'd0, 1,0)));
    end
    foreach (q[i]) begin
      mem_ready = q[i][20]; branch_taken = q[i][19]; #1;
      checks++;
      if (obs !== q[i][18:0]) begin errors++; $display("FAIL beq cycle %0d got %h expected %h", i, obs, q[i][18:0]); end
      @(posedge clk); #1;
    end
    branch_taken = 1'b0;
  endtask

  task automatic test_jumps();
    logic [20:0] q[$];
    logic [6:0]  ops[$];
    // JALR
    for (int i = 0; i < 5; i++) ops.push_back(7'b1100111);
    q.push_back(fetch_ok());
    q.push_back(v(1,0, mk(0,0,0,0,0,0, 2'd1,2'd1,2'd0, 3'd1, 2'd0, 0,0)));
    q.push_back(v(1,0, mk(0,0,0,0,1,0, 2'd2,2'd1,2'd0, 3'd1, 2'd2, 0,0)));
    q.push_back(v(1,0, mk(0,0,0,0,0,0, 2'd1,2'd2,2'd0, 3'd1, 2'd0, 0,0)));
    q.push_back(v(1,0, mk(0,0,0,0,0,1, 2'd0,2'd0,2'd0, 3'd1, 2'd0, 1,0)));
    // JAL
    for (int i = 0; i < 4; i++) ops.push_back(7'b1101111);
    q.push_back(fetch_ok());
    q.push_back(v(1,0, mk(0,0,0,0,0,0, 2'd1,2'd1,2'd0, 3'd5, 2'd0, 0,0)));
    q.push_back(v(1,0, mk(0,0,0,0,1,0, 2'd1,2'd2,2'd0, 3'd5, 2'd0, 0,0)));
    q.push_back(v(1,0, mk(0,0,0,0,0,1, 2'd0,2'd0,2'd0, 3'd5, 2'd0, 1,0)));
    // AUIPC: straight from DECODE to ALUWB
    for (int i = 0; i < 3; i++) ops.push_back(7'b0010111);
    q.push_back(fetch_ok());
    q.push_back(v(1,0, mk(0,0,0,0,0,0, 2'd1,2'd1,2'd0, 3'd4, 2'd0, 0,0)));
    q.push_back(v(1,0, mk(0,0,0,0,0,1, 2'd0,2'd0,2'd0, 3'd4, 2'd0, 1,0)));
    // LUI: zero + imm
    for (int i = 0; i < 4; i++) ops.push_back(7'b0110111);
    q.push_back(fetch_ok());
    q.push_back(v(1,0, mk(0,0,0,0,0,0, 2'd1,2'd1,2'd0, 3'd4, 2'd0, 0,0)));
    q.push_back(v(1,0, mk(0,0,0,0,0,0, 2'd3,2'd1,2'd0, 3'd4, 2'd0, 0,0)));
    q.push_back(v(1,0, mk(0,0,0,0,0,1, 2'd0,2'd0,2'd0, 3'd4, 2'd0, 1,0)));
    // R-type
    for (int i = 0; i < 4; i++) ops.push_back(7'b0110011);
    q.push_back(fetch_ok());
    q.push_back(v(1,0, mk(0,0,0,0,0,0, 2'd1,2'd1,2'd0, 3'd0, 2'd0, 0,0)));
    q.push_back(v(1,0, mk(0,0,0,0,0,0, 2'd2,2'd0,2'd2, 3'd0, 2'd0, 0,0)));
    q.push_back(v(1,0, mk(0,0,0,0,0,1, 2'd0,2'd0,2'd0, 3'd0, 2'd0, 1,0)));
    foreach (q[i]) begin
      op = ops[i]; mem_ready = q[i][20]; branch_taken = q[i][19]; #1;
      checks++;
      if (obs !== q[i][18:0]) begin errors++; $display("FAIL jump_alu cycle %0d op %b got %h expected %h", i, ops[i], obs, q[i][18:0]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    logic [20:0] q[$];
    op = 7'b0000000;
    q.push_back(fetch_ok());
    q.push_back(v(1,0, mk(0,0,0,0,0,0, 2'd1,2'd1,2'd0, 3'd0, 2'd0, 0,0)));
    for (int i = 0; i < 20; i++)
      q.push_back(v(i[0], ~i[0], mk(0,0,0,0,0,0, 2'd0,2'd0,2'd0, 3'd0, 2'd0, 0,1)));
    foreach (q[i]) begin
      mem_ready = q[i][20]; branch_taken = q[i][19]; #1;
      checks++;
      if (obs !== q[i][18:0]) begin errors++; $display("FAIL illegal cycle %0d got %h expected %h", i, obs, q[i][18:0]); end
      @(posedge clk); #1;
    end
    branch_taken = 1'b0;
    rst_n = 1'b0; #1;
    checks++;
    if (obs !== 19'd0) begin errors++; $display("FAIL illegal_async_clear got %h expected %h", obs, 19'd0); end
    @(posedge clk); #1;
    rst_n = 1'b1; mem_ready = 1'b1; #1;
    checks++;
    if (obs !== 19'd0) begin errors++; $display("FAIL illegal_after_reset got %h expected %h", obs, 19'd0); end
    @(posedge clk); #1;
  endtask

  task automatic test_store_reset();
    logic [20:0] q[$];
    logic [18:0] e_mw;
    int nmw = 0;
    op = 7'b0100011;
    e_mw = mk(1,1,1,0,0,0, 2'd0,2'd0,2'd0, 3'd2, 2'd0, 0,0);
    q.push_back(fetch_ok());
    q.push_back(v(1,0, mk(0,0,0,0,0,0, 2'd1,2'd1,2'd0, 3'd2, 2'd0, 0,0)));
    q.push_back(v(1,0, mk(0,0,0,0,0,0, 2'd2,2'd1,2'd0, 3'd2, 2'd0, 0,0)));
    q.push_back(v(0,0, e_mw));
    foreach (q[i]) begin
      mem_ready = q[i][20]; branch_taken = q[i][19]; #1;
      checks++;
      if (obs !== q[i][18:0]) begin errors++; $display("FAIL sw cycle %0d got %h expected %h", i, obs, q[i][18:0]); end
      @(posedge clk); #1;
    end
    mem_ready = 1'b0; #1;
    checks++;
    if (obs !== e_mw) begin errors++; $display("FAIL sw_wait_hold got %h expected %h", obs, e_mw); end
    rst_n = 1'b0; #1;
    checks++;
    if (obs !== 19'd0) begin errors++; $display("FAIL sw_async_reset got %h expected %h", obs, 19'd0); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    q.delete();
    q.push_back(v(1,0, 19'd0));
    q.push_back(fetch_ok());
    q.push_back(v(1,0, mk(0,0,0,0,0,0, 2'd1,2'd1,2'd0, 3'd2, 2'd0, 0,0)));
    q.push_back(v(1,0, mk(0,0,0,0,0,0, 2'd2,2'd1,2'd0, 3'd2, 2'd0, 0,0)));
    q.push_back(v(1,0, mk(1,1,1,0,0,0, 2'd0,2'd0,2'd0, 3'd2, 2'd0, 1,0)));
    foreach (q[i]) begin
      mem_ready = q[i][20]; branch_taken = q[i][19]; #1;
      if (i < 4) nmw += int'(MemWrite);
      checks++;
      if (obs !== q[i][18:0]) begin errors++; $display("FAIL sw_restart cycle %0d got %h expected %h", i, obs, q[i][18:0]); end
      @(posedge clk); #1;
    end
    checks++;
    if (nmw != 0) begin errors++; $display("FAIL sw_memwrite_after_reset got %0d expected 0", nmw); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lw_waits();
    test_branch();
    test_jumps();
    test_illegal();
    test_store_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
